xor32_generator: RTL

- Sequential xorshift128 random-word source that consumes a 128-bit seed, for example the first four words of the Xor32Initializer output or a host-supplied seed.
- Each accepted transfer produces SIZE consecutive 32-bit xorshift outputs in parallel, using the same recurrence as the initializer.
- Sits between the seed source and downstream consumers (weight init, dropout masks) behind a valid/ready stream interface.

---
 rtl/xor32_generator.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/xor32_generator.sv
// -----------------------------------------------------------------------------
// xor32_generator
//
// Purpose:
//   Sequential xorshift128 random-word source. A 128-bit seed is loaded and
//   each accepted transfer then yields SIZE consecutive 32-bit xorshift
//   outputs in parallel. The output side is a valid/ready stream.
//
// Ports:
//   iClk        clock, rising edge
//   iRst        synchronous reset, active low
//   iSeed       128-bit seed, word k = iSeed[k*32+:32], word 0 is the oldest
//   iSeedValid  one-cycle request to load iSeed
//   oSeedBusy   high while the generator is in FILL
//   oRandom     current block, word i = oRandom[i*32+:32]
//   oValid      oRandom holds a valid block
//   iReady      consumer accepts the block
//   oCount      blocks accepted since the last seed load (wraps)
// -----------------------------------------------------------------------------
module xor32_generator #(
    parameter int unsigned SIZE  = 8,             // words per block, >= 1
    parameter logic [31:0] SEED0 = 32'd123456789,
    parameter logic [31:0] SEED1 = 32'd362436069,
    parameter logic [31:0] SEED2 = 32'd521288629,
    parameter logic [31:0] SEED3 = 32'd88675123
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [127:0]        iSeed,
    input  logic                iSeedValid,
    output logic                oSeedBusy,
    output logic [SIZE*32-1:0]  oRandom,
    output logic                oValid,
    input  logic                iReady,
    output logic [31:0]         oCount
);

    localparam int unsigned WIN_W = (SIZE + 32'd4) * 32'd32;
    localparam logic [127:0] DEFAULT_STATE = {SEED3, SEED2, SEED1, SEED0};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } fsm_t;

    // One xorshift128 step: oldest word x[k-4] and newest word x[k-1]
    // produce x[k]. All shifts are logical and truncated to 32 bits.
    function automatic logic [31:0] f_step(input logic [31:0] oldest,
                                           input logic [31:0] newest);
        logic [31:0] t;
        t = oldest ^ (oldest << 11);
        return newest ^ (newest >> 19) ^ t ^ (t >> 8);
    endfunction

    // Unrolled recurrence over the window x[0..SIZE+3]; x[0..3] is the state.
    function automatic logic [WIN_W-1:0] f_window(input logic [127:0] st);
        logic [31:0]      x [0:SIZE+3];
        logic [WIN_W-1:0] packed_win;
        for (int k = 0; k < 4; k++) begin
            x[k] = st[k*32 +: 32];
        end
        for (int k = 4; k < int'(SIZE) + 4; k++) begin
            x[k] = f_step(x[k-4], x[k-1]);
        end
        for (int k = 0; k < int'(SIZE) + 4; k++) begin
            packed_win[k*32 +: 32] = x[k];
        end
        return packed_win;
    endfunction

    fsm_t               r_fsm;
    logic [127:0]       r_state;
    logic [SIZE*32-1:0] r_random;
    logic               r_valid;
    logic               r_busy;
    logic [31:0]        r_count;

    logic [WIN_W-1:0]   w_window;
    logic [SIZE*32-1:0] w_block;
    logic [127:0]       w_next_state;
    logic [127:0]       w_seed_state;
    logic               w_transfer;

    assign w_window     = f_window(r_state);
    // Block word i is x[i+4]; the new state is the last four window words.
    assign w_block      = w_window[WIN_W-1 -: SIZE*32];
    assign w_next_state = w_window[WIN_W-1 -: 128];
    assign w_transfer   = r_valid & iReady;

    // Seed selection: an all-zero state never leaves zero, so substitute defaults.
    always_comb begin
        if (iSeed == 128'd0) begin
            w_seed_state = DEFAULT_STATE;
        end else begin
            w_seed_state = iSeed;
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            r_fsm    <= ST_IDLE;
            r_state  <= DEFAULT_STATE;
            r_random <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_count  <= 32'd0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    r_valid <= 1'b0;
                    if (iSeedValid) begin
                        r_state <= w_seed_state;
                        r_count <= 32'd0;
                        r_busy  <= 1'b1;
                        r_fsm   <= ST_FILL;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (iSeedValid) begin
                        // A newer seed restarts FILL; the pending block is dropped.
                        r_state <= w_seed_state;
                        r_count <= 32'd0;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                    end else begin
                        r_random <= w_block;
                        r_state  <= w_next_state;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_fsm    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (iSeedValid) begin
                        // Seed beats a simultaneous transfer: count restarts at 0.
                        r_state <= w_seed_state;
                        r_count <= 32'd0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b1;
                        r_fsm   <= ST_FILL;
                    end else if (w_transfer) begin
                        r_random <= w_block;
                        r_state  <= w_next_state;
                        r_count  <= r_count + 32'd1;
                    end else begin
                        r_random <= r_random;
                    end
                end
                default: begin
                    r_fsm   <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign oRandom   = r_random;
    assign oValid    = r_valid;
    assign oSeedBusy = r_busy;
    assign oCount    = r_count;

endmodule
